memfifo_read_scheduler: RTL and testbench

- Sequences MEMFIFO reads for queued data requests.
- Accepts data requests (packet count each) into a small queue.
- Serves one request at a time: waits for MEMFIFO_DATA_READY, applies an initial settle delay, then issues evenly spaced one-clock memfifo_re pulses until the request's word count is exhausted.
- Sits between the data-request decoder and the MEMFIFO/TOP_SERDES read path; replaces free-running re generation with a flow-controlled scheduler.

---
 rtl/memfifo_sched_pkg.sv | 26 ++
 rtl/memfifo_req_queue.sv | 58 +++++
 rtl/memfifo_read_scheduler.sv | 161 ++++++++++++++++
 tb/tb_memfifo_read_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memfifo_sched_pkg.sv
// Shared types and sizing helpers for the MEMFIFO read scheduler.
// Imported by the request queue and the scheduler top.
package memfifo_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_PREDELAY,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int total_w(input int pkt_w, input int wpp);
        return pkt_w + $clog2(wpp);
    endfunction

    localparam int PKT_W_DEF   = 16;
    localparam int WPP_DEF     = 2;
    localparam int TOTAL_W     = total_w(PKT_W_DEF, WPP_DEF);

endpackage

// File: rtl/memfifo_req_queue.sv
// Small synchronous FIFO holding pending request packet counts.
// Caller never pushes when full nor pops when empty.
module memfifo_req_queue
    import memfifo_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [W-1:0]              head,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;

    // storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointer and occupancy tracking, flush empties in one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + LW'(push) - LW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign level = cnt;

endmodule

// File: rtl/memfifo_read_scheduler.sv
// Flow-controlled MEMFIFO read scheduler: one queued request at a time,
// wait for data ready, settle delay, then evenly spaced re pulses.
module memfifo_read_scheduler
    import memfifo_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 4,
    parameter int PKT_W         = 16,
    parameter int WORDS_PER_PKT = 2,
    parameter int EXTRA_DELAY   = 11,
    parameter int GAP_W         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [PKT_W-1:0]                req_packet_no,
    input  logic                            fifo_data_ready,
    input  logic [GAP_W-1:0]                gap_cfg,
    input  logic                            abort,
    output logic                            memfifo_re,
    output logic                            last_memfifo_re,
    output logic                            req_done,
    output logic                            busy,
    output logic [lvl_w(QUEUE_DEPTH)-1:0]   queue_level
);

    localparam int TW    = total_w(PKT_W, WORDS_PER_PKT);
    localparam int WSH   = $clog2(WORDS_PER_PKT);
    localparam int LW    = lvl_w(QUEUE_DEPTH);
    localparam int DLY_W = (EXTRA_DELAY > 0) ? $clog2(EXTRA_DELAY + 1) : 1;

    state_t            state, state_n;
    logic [TW-1:0]     total, total_n;
    logic [TW-1:0]     re_cnt, re_cnt_n;
    logic [GAP_W-1:0]  gap_r, gap_n;
    logic [GAP_W-1:0]  gcnt, gcnt_n;
    logic [DLY_W-1:0]  dly, dly_n;
    logic              push, pop;
    logic [PKT_W-1:0]  head;
    logic [TW-1:0]     head_total;
    logic [LW-1:0]     level;
    logic              re_q, last_q, done_q;

    assign req_ready  = ~rst & ~abort & (level < LW'(QUEUE_DEPTH));
    assign push       = req_valid & req_ready;
    assign head_total = TW'(head) << WSH;

    memfifo_req_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (PKT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_packet_no),
        .pop       (pop),
        .flush     (abort),
        .head      (head),
        .level     (level)
    );

    // next-state and counter updates; abort overrides every state
    always_comb begin
        state_n  = state;
        total_n  = total;
        re_cnt_n = re_cnt;
        gap_n    = gap_r;
        gcnt_n   = gcnt;
        dly_n    = dly;
        pop      = 1'b0;
        if (abort) begin
            state_n  = S_IDLE;
            total_n  = '0;
            re_cnt_n = '0;
            gap_n    = '0;
            gcnt_n   = '0;
            dly_n    = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (level != '0) begin
                        pop      = 1'b1;
                        total_n  = head_total;
                        gap_n    = gap_cfg;
                        re_cnt_n = '0;
                        state_n  = (head_total == '0) ? S_DONE : S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (fifo_data_ready) begin
                        if (EXTRA_DELAY == 0) begin
                            state_n = S_ISSUE;
                        end else begin
                            dly_n   = DLY_W'(EXTRA_DELAY);
                            state_n = S_PREDELAY;
                        end
                    end
                end
                S_PREDELAY: begin
                    dly_n = dly - DLY_W'(1);
                    if (dly == DLY_W'(1)) begin
                        state_n = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    re_cnt_n = re_cnt + TW'(1);
                    if (re_cnt + TW'(1) == total) begin
                        state_n = S_DONE;
                    end else if (gap_r != '0) begin
                        gcnt_n  = gap_r;
                        state_n = S_GAP;
                    end
                end
                S_GAP: begin
                    gcnt_n = gcnt - GAP_W'(1);
                    if (gcnt == GAP_W'(1)) begin
                        state_n = S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // state, counters and registered pulse outputs decoded from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            total  <= '0;
            re_cnt <= '0;
            gap_r  <= '0;
            gcnt   <= '0;
            dly    <= '0;
            re_q   <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            total  <= total_n;
            re_cnt <= re_cnt_n;
            gap_r  <= gap_n;
            gcnt   <= gcnt_n;
            dly    <= dly_n;
            re_q   <= (state_n == S_ISSUE);
            last_q <= (state_n == S_ISSUE) && (re_cnt_n + TW'(1) == total_n);
            done_q <= (state_n == S_DONE);
        end
    end

    assign memfifo_re      = re_q & ~abort;
    assign last_memfifo_re = last_q & ~abort;
    assign req_done        = done_q & ~abort;
    assign busy            = (state != S_IDLE);
    assign queue_level     = level;

endmodule

// File: tb/tb_memfifo_read_scheduler.sv
// Self-checking bench: directed scenarios plus randomized batches checked
// against an event-time model of request scheduling.
module tb_memfifo_read_scheduler;

    localparam int ED = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_packet_no = '0;
    logic        fifo_data_ready = 1'b0;
    logic [3:0]  gap_cfg = '0;
    logic        abort = 1'b0;
    logic        memfifo_re;
    logic        last_memfifo_re;
    logic        req_done;
    logic        busy;
    logic [2:0]  queue_level;

    memfifo_read_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_packet_no   (req_packet_no),
        .fifo_data_ready (fifo_data_ready),
        .gap_cfg         (gap_cfg),
        .abort           (abort),
        .memfifo_re      (memfifo_re),
        .last_memfifo_re (last_memfifo_re),
        .req_done        (req_done),
        .busy            (busy),
        .queue_level     (queue_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int gap_hist[int];
    bit rdy_hist[int];
    int re_log[$];
    int last_log[$];
    int done_log[$];

    always @(negedge clk) begin
        gap_hist[cyc] = int'(gap_cfg);
        rdy_hist[cyc] = fifo_data_ready;
        if (memfifo_re) re_log.push_back(cyc);
        if (last_memfifo_re) last_log.push_back(cyc);
        if (req_done) done_log.push_back(cyc);
    end

    int vecs = 0;
    int errs = 0;
    bit gap_rand = 0;
    bit rdy_rand = 0;
    int bp[$];
    int c0 = 0;
    int abort_at = -1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (gap_rand) gap_cfg = 4'($urandom_range(0, 3));
        if (rdy_rand) fifo_data_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_all();
        re_log.delete();
        last_log.delete();
        done_log.delete();
        c0 = cyc;
        foreach (bp[i]) begin
            req_valid = 1'b1;
            req_packet_no = 16'(bp[i]);
            chk("push_ready", longint'(req_ready), 1);
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic cmp_q(input string tag, input int a[$], input int b[$]);
        int n;
        chk({tag, "_count"}, a.size(), b.size());
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_cycle"}, a[i], b[i]);
        end
    endtask

    task automatic model_check();
        int er[$];
        int el[$];
        int ed[$];
        int t, w, s, g, n, lim, lst;
        lim = (abort_at >= 0) ? abort_at : 32'h7fffffff;
        t = c0 + 1;
        foreach (bp[i]) begin
            if (t >= lim) break;
            g = gap_hist[t];
            n = bp[i] * 2;
            if (n == 0) begin
                if (t + 1 < lim) ed.push_back(t + 1);
                t = t + 2;
            end else begin
                w = t + 1;
                while (w < cyc && !rdy_hist[w]) w++;
                s = w + 1 + ED;
                for (int k = 0; k < n; k++) begin
                    if (s + k * (g + 1) >= lim) break;
                    er.push_back(s + k * (g + 1));
                end
                lst = s + (n - 1) * (g + 1);
                if (lst < lim) el.push_back(lst);
                if (lst + 1 < lim) ed.push_back(lst + 1);
                t = lst + 2;
            end
        end
        cmp_q("re", re_log, er);
        cmp_q("last", last_log, el);
        cmp_q("done", done_log, ed);
    endtask

    task automatic finish_batch();
        int n;
        n = 0;
        if (abort_at >= 0) begin
            while (cyc < abort_at && n < 5000) begin
                step();
                n++;
            end
            abort = 1'b1;
            req_valid = 1'b1;
            req_packet_no = 16'd5;
            step();
            abort = 1'b0;
            req_valid = 1'b0;
            chk("abort_level", longint'(queue_level), 0);
            chk("abort_busy", longint'(busy), 0);
            repeat (40) step();
        end else begin
            while (!(busy == 1'b0 && queue_level == 3'd0) && n < 5000) begin
                step();
                n++;
            end
            chk("drain_in_time", longint'(n < 5000), 1);
            repeat (3) step();
        end
        model_check();
        abort_at = -1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_re", longint'(memfifo_re), 0);
        chk("rst_last", longint'(last_memfifo_re), 0);
        chk("rst_done", longint'(req_done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_level", longint'(queue_level), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", longint'(req_ready), 1);

        fifo_data_ready = 1'b1;
        gap_cfg = 4'd7;
        bp = '{3};
        push_all();
        finish_batch();

        fifo_data_ready = 1'b0;
        gap_cfg = 4'd1;
        bp = '{1, 2, 0, 3, 1};
        push_all();
        req_valid = 1'b1;
        chk("full_ready", longint'(req_ready), 0);
        chk("full_level", longint'(queue_level), 4);
        req_valid = 1'b0;
        fifo_data_ready = 1'b1;
        finish_batch();

        gap_cfg = 4'd0;
        bp = '{2};
        push_all();
        finish_batch();

        gap_cfg = 4'd2;
        bp = '{0, 1};
        push_all();
        finish_batch();

        gap_cfg = 4'd3;
        bp = '{10, 2, 4};
        push_all();
        abort_at = c0 + 1 + 2 + ED + 2 * 4 + 1;
        finish_batch();

        gap_cfg = 4'd0;
        bp = '{32768};
        push_all();
        abort_at = c0 + 1 + 2 + ED + 40;
        finish_batch();

        gap_rand = 1'b1;
        rdy_rand = 1'b1;
        for (int b = 0; b < 10; b++) begin
            bp.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) bp.push_back($urandom_range(0, 3));
            push_all();
            finish_batch();
        end
        gap_rand = 1'b0;
        rdy_rand = 1'b0;
        fifo_data_ready = 1'b1;

        gap_cfg = 4'd0;
        bp = '{10, 3, 3};
        push_all();
        n = 0;
        while (!memfifo_re && n < 100) begin
            step();
            n++;
        end
        chk("reach_issue", longint'(memfifo_re), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_re", longint'(memfifo_re), 0);
        chk("arst_last", longint'(last_memfifo_re), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_level", longint'(queue_level), 0);
        chk("arst_ready", longint'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        bp = '{1};
        push_all();
        finish_batch();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
